// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs field-level instruction requests (opcode, registers, funct, immediate)
// into 32-bit RV32I words. Words are buffered in a small FIFO and written in
// order into instruction memory at consecutive word addresses. Requests with an
// unsupported opcode or a misaligned branch/jump target are consumed without
// being written, and o_Error pulses for one cycle.
//
// Optional feature: define ENC_RANGE_CHECK_EN to also reject immediates that
// do not fit their instruction field. When it is undefined, immediates are
// truncated to the field width.
//
// Parameters
//   P_DEPTH      FIFO entries (power of two, >= 2)
//   P_ADDR_W     byte-address width
//   P_BASE_ADDR  first write address after reset/clear (word aligned)
//
// Ports
//   i_CLK, i_RST        clock, synchronous active-high reset
//   i_Clear             flush FIFO, reload address, zero o_Count
//   i_Valid / o_Ready   request handshake
//   i_OpCode, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Imm   request fields
//   o_MemWE, o_MemAddr, o_MemWD, i_MemReady                 memory write port
//   o_Error             one-cycle pulse after a rejected request
//   o_Count             words written since reset/clear (saturating)
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Valid and the payload must be held until
// that edge; ready never depends on valid. On the memory side o_MemWD and
// o_MemAddr stay stable while o_MemWE is high and i_MemReady is low.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int                  P_DEPTH     = 4,
  parameter int                  P_ADDR_W    = 32,
  parameter logic [P_ADDR_W-1:0] P_BASE_ADDR = '0
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_Clear,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic [6:0]          i_OpCode,
  input  logic [4:0]          i_Rd,
  input  logic [4:0]          i_Rs1,
  input  logic [4:0]          i_Rs2,
  input  logic [2:0]          i_Funct3,
  input  logic [6:0]          i_Funct7,
  input  logic [20:0]         i_Imm,
  output logic                o_MemWE,
  output logic [P_ADDR_W-1:0] o_MemAddr,
  output logic [31:0]         o_MemWD,
  input  logic                i_MemReady,
  output logic                o_Error,
  output logic [15:0]         o_Count
);

  localparam int PTR_W = $clog2(P_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(P_DEPTH);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013; // addi x0, x0, 0

  // ---------------------------------------------------------------------------
  // Immediate range qualification
  // ---------------------------------------------------------------------------
  logic imm_i_ok; // I/S-type: 12-bit signed
  logic imm_b_ok; // B-type: 13-bit signed

`ifdef ENC_RANGE_CHECK_EN
  // A value fits an N-bit signed field when every bit above the field equals
  // the field's sign bit. The J-type field is 21 bits wide, the same as i_Imm,
  // so every jal immediate is in range and needs only the alignment check.
  assign imm_i_ok = (i_Imm[20:11] == {10{i_Imm[11]}});
  assign imm_b_ok = (i_Imm[20:12] == {9{i_Imm[12]}});
`else
  assign imm_i_ok = 1'b1;
  assign imm_b_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (i_OpCode)
      OP_LW: begin
        // funct3 is fixed to word width regardless of i_Funct3
        enc_word  = {i_Imm[11:0], i_Rs1, 3'b010, i_Rd, OP_LW};
        enc_legal = imm_i_ok;
      end
      OP_ADDI: begin
        enc_word  = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, OP_ADDI};
        enc_legal = imm_i_ok;
      end
      OP_SW: begin
        enc_word  = {i_Imm[11:5], i_Rs2, i_Rs1, 3'b010, i_Imm[4:0], OP_SW};
        enc_legal = imm_i_ok;
      end
      OP_RTYPE: begin
        enc_word  = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, OP_RTYPE};
        enc_legal = 1'b1;
      end
      OP_BEQ: begin
        // Branch offsets are in half-words; bit 0 is not encoded, so a set
        // bit 0 would silently change the target and is rejected instead.
        enc_word  = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, i_Funct3,
                     i_Imm[4:1], i_Imm[11], OP_BEQ};
        enc_legal = !i_Imm[0] && imm_b_ok;
      end
      OP_JAL: begin
        enc_word  = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12],
                     i_Rd, OP_JAL};
        enc_legal = !i_Imm[0];
      end
      OP_NOP: begin
        enc_word  = NOP_WORD;
        enc_legal = 1'b1;
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]         mem_q [P_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [P_ADDR_W-1:0] addr_q,   addr_d;
  logic [15:0]         count_q,  count_d;
  logic                err_q,    err_d;
  // Low for the first cycle after reset so o_Ready rises only once reset
  // has been released for a full clock.
  logic                init_q,   init_d;

  logic fifo_full;
  logic fifo_empty;
  logic req_fire;
  logic push;
  logic pop;

  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);

  // Ready comes from registered occupancy only: a pop in the same cycle does
  // not reopen a full FIFO. Clear and reset both block new requests.
  assign o_Ready  = init_q && !fifo_full && !i_Clear && !i_RST;
  assign req_fire = i_Valid && o_Ready;
  assign push     = req_fire && enc_legal;

  // Words about to be discarded by clear/reset are not offered to memory.
  assign o_MemWE  = !fifo_empty && !i_Clear && !i_RST;
  assign pop      = o_MemWE && i_MemReady;

  assign o_MemWD   = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign o_MemAddr = addr_q;
  assign o_Error   = err_q;
  assign o_Count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = 1'b0;
    init_d   = 1'b1;

    if (i_Clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = P_BASE_ADDR;
      count_d  = 16'h0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + P_ADDR_W'(4);
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      err_d = req_fire && !enc_legal;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= P_BASE_ADDR;
      count_q  <= 16'h0;
      err_q    <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      init_q   <= init_d;
    end
  end

  // Storage needs no reset: an entry is only read while occupancy covers it.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

endmodule
